// File: rtl/sync_fifo_flagged_if.sv
// rtl/sync_fifo_flagged_if.sv - handshake bundle for sync_fifo_flagged
//
// Purpose: groups the write, read and status signals of sync_fifo_flagged.
// Parameters: FIFO_WIDTH (word width), FIFO_DEPTH (entries, power of two).
// Signals:
//   i_wen, i_wdata          write request and data            (master -> slave)
//   i_ren                   read request                      (master -> slave)
//   o_rdata, o_rd_valid     read data and its qualifier       (slave -> master)
//   o_wr_ack                previous-cycle write accepted      (slave -> master)
//   o_full, o_empty         occupancy extremes                 (slave -> master)
//   o_almost_full/_empty    threshold warnings                 (slave -> master)
//   o_count                 occupancy 0..FIFO_DEPTH            (slave -> master)
//   o_overflow, o_underflow previous-cycle rejected write/read (slave -> master)
interface sync_fifo_flagged_if #(
  parameter int FIFO_WIDTH = 4,
  parameter int FIFO_DEPTH = 8
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic                  i_wen;
  logic [FIFO_WIDTH-1:0] i_wdata;
  logic                  i_ren;
  logic [FIFO_WIDTH-1:0] o_rdata;
  logic                  o_rd_valid;
  logic                  o_wr_ack;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_almost_full;
  logic                  o_almost_empty;
  logic [AW:0]           o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_wen, i_wdata, i_ren,
    input  o_rdata, o_rd_valid, o_wr_ack, o_full, o_empty,
           o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_wen, i_wdata, i_ren,
    output o_rdata, o_rd_valid, o_wr_ack, o_full, o_empty,
           o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_flagged.sv
// rtl/sync_fifo_flagged.sv - single-clock FIFO with occupancy count and status flags
//
// Purpose: FIFO_DEPTH x FIFO_WIDTH register FIFO reporting live occupancy,
// almost-full/almost-empty warnings and per-cycle overflow/underflow pulses.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// undefined gives a registered read with one cycle of latency.
// Ports:
//   i_clk    clock, all logic on the rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      sync_fifo_flagged_if.slave (write/read handshake and status)
module sync_fifo_flagged #(
  parameter int FIFO_WIDTH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sync_fifo_flagged_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  // Extra MSB is the wrap bit: equal low bits with differing MSB means full.
  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;

  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A simultaneous read frees the slot, so a write into a full FIFO is
  // still accepted when a read is requested in the same cycle.
  assign wr_acc = bus.i_wen && (!full || bus.i_ren);
  assign rd_acc = bus.i_ren && !empty;

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wptr[AW-1:0]] <= bus.i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.i_wen && !wr_acc;
      underflow_q <= bus.i_ren && !rd_acc;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown combinationally; the empty mux keeps o_rdata at 0
  // out of reset and hides stale storage while nothing is queued.
  assign bus.o_rdata    = empty ? '0 : mem[rptr[AW-1:0]];
  assign bus.o_rd_valid = !empty;
`else
  logic [FIFO_WIDTH-1:0] rdata_q;
  logic                  rd_valid_q;

  // The head is sampled on the accepting edge, before any same-edge write
  // to that slot lands, so full + read + write returns the old head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem[rptr[AW-1:0]];
      end
    end
  end

  assign bus.o_rdata    = rdata_q;
  assign bus.o_rd_valid = rd_valid_q;
`endif

  assign bus.o_wr_ack       = wr_ack_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;
  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (count >= (AW+1)'(AF_THRESH));
  assign bus.o_almost_empty = (count <= (AW+1)'(AE_THRESH));
  assign bus.o_count        = count;
endmodule
